// File: rtl/addr_router_pkg.sv
// addr_router_pkg: shared FSM states, KSEG prefix and default region map for addr_router
package addr_router_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [1:0] KSEG_PREFIX = 2'b10;
  localparam logic [63:0] DEF_REGION_MASK = {32'hFFC00000, 32'hFFC00000};
  localparam logic [63:0] DEF_REGION_FLAG = {32'h80400000, 32'h80000000};
endpackage

// File: rtl/addr_router_decode.sv
// addr_router_decode: combinational virtual-to-physical translate and region match
module addr_router_decode
  import addr_router_pkg::*;
#(
  parameter int NUM_TGT = 3,
  parameter int PADDR_W = 20,
  parameter logic [(NUM_TGT-1)*32-1:0] REGION_MASK = DEF_REGION_MASK,
  parameter logic [(NUM_TGT-1)*32-1:0] REGION_FLAG = DEF_REGION_FLAG
) (
  input  logic [31:0]        vaddr,
  output logic [PADDR_W-1:0] paddr,
  output logic [NUM_TGT-1:0] sel,
  output logic               hit
);
  logic [31:0] taddr;
  assign taddr = (vaddr[31:30] == KSEG_PREFIX) ? {4'h0, vaddr[27:0]} : vaddr;
  assign paddr = taddr[PADDR_W+1:2];
  // Descending scan so the lowest matching index overrides; a miss falls back to the top channel.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = NUM_TGT - 2; i >= 0; i--) begin
      if ((vaddr & REGION_MASK[i*32 +: 32]) == REGION_FLAG[i*32 +: 32]) begin
        sel    = '0;
        sel[i] = 1'b1;
        hit    = 1'b1;
      end
    end
    if (!hit) sel[NUM_TGT-1] = 1'b1;
  end
endmodule

// File: rtl/addr_router.sv
// addr_router: one-at-a-time request router with fixed-latency target strobe.
// Define ADDR_ROUTER_ERR_EN to answer unmapped addresses with an error response instead of the top channel.
module addr_router
  import addr_router_pkg::*;
#(
  parameter int NUM_TGT     = 3,
  parameter int PADDR_W     = 20,
  parameter int WAIT_CYCLES = 0,
  parameter logic [(NUM_TGT-1)*32-1:0] REGION_MASK = DEF_REGION_MASK,
  parameter logic [(NUM_TGT-1)*32-1:0] REGION_FLAG = DEF_REGION_FLAG
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ_VALID,
  output logic               REQ_READY,
  input  logic [31:0]        REQ_VADDR,
  input  logic               REQ_WE,
  output logic [PADDR_W-1:0] PADDR,
  output logic [NUM_TGT-1:0] TGT_SEL,
  output logic               TGT_EN,
  output logic               TGT_WE,
  output logic               RESP_VALID,
  output logic               RESP_ERR
);
`ifdef ADDR_ROUTER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [PADDR_W-1:0] dec_paddr;
  logic [NUM_TGT-1:0] dec_sel;
  logic dec_hit, accept, err_acc, err_q;
  addr_router_decode #(
    .NUM_TGT(NUM_TGT),
    .PADDR_W(PADDR_W),
    .REGION_MASK(REGION_MASK),
    .REGION_FLAG(REGION_FLAG)
  ) u_decode (
    .vaddr(REQ_VADDR),
    .paddr(dec_paddr),
    .sel(dec_sel),
    .hit(dec_hit)
  );
  assign REQ_READY  = (state == IDLE);
  assign accept     = REQ_VALID && REQ_READY;
  assign err_acc    = ERR_EN && !dec_hit;
  assign TGT_EN     = (state == ACCESS);
  assign RESP_VALID = (state == RESP);
  assign RESP_ERR   = ERR_EN && RESP_VALID && err_q;
  always_comb begin
    state_nxt = (state == IDLE)   ? (accept ? (err_acc ? RESP : ACCESS) : IDLE) :
                (state == ACCESS) ? ((cnt == '0) ? RESP : ACCESS) : IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      PADDR   <= '0;
      TGT_SEL <= '0;
      TGT_WE  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        PADDR   <= dec_paddr;
        TGT_SEL <= err_acc ? '0 : dec_sel;
        TGT_WE  <= REQ_WE;
        cnt     <= CNT_W'(WAIT_CYCLES);
        err_q   <= err_acc;
      end else if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_addr_router.sv
// tb_addr_router: randomized scoreboard bench over three WAIT_CYCLES settings (0, 2, 3)
module tb_addr_router;
`ifdef ADDR_ROUTER_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [19:0] m_paddr(input logic [31:0] v);
    logic [31:0] t;
    t = (v >= 32'h80000000 && v < 32'hC0000000) ? v % 32'h10000000 : v;
    return 20'((t / 4) % 32'h100000);
  endfunction

  function automatic int m_region(input logic [31:0] v);
    if (v >= 32'h80000000 && v < 32'h80400000) return 0;
    if (v >= 32'h80400000 && v < 32'h80800000) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] dir [4];
    dir = '{32'h80001234, 32'h80400008, 32'hBFD003F8, 32'h803FFFFC};
    case ($urandom_range(0, 5))
      0: return dir[$urandom_range(0, 3)];
      1: return 32'h80000000 + $urandom_range(0, 32'h3FFFFF);
      2: return 32'h80400000 + $urandom_range(0, 32'h3FFFFF);
      3: return 32'hA0000000 + $urandom_range(0, 32'hFFFFFF);
      default: return $urandom;
    endcase
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int W = (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    typedef struct {
      int         t;
      logic [2:0] sel;
      logic       we;
      logic       err;
    } txn_t;
    logic rst, valid, we, ready, tgt_en, tgt_we, resp_valid, resp_err;
    logic [31:0] vaddr;
    logic [19:0] paddr, last_pa;
    logic [2:0] sel, last_sel;
    txn_t q[$];
    int cyc = 0;
    int free_at = 0;
    bit started = 0;

    addr_router #(.WAIT_CYCLES(W)) dut (
      .CLK(clk), .RST(rst), .REQ_VALID(valid), .REQ_READY(ready),
      .REQ_VADDR(vaddr), .REQ_WE(we), .PADDR(paddr), .TGT_SEL(sel),
      .TGT_EN(tgt_en), .TGT_WE(tgt_we), .RESP_VALID(resp_valid), .RESP_ERR(resp_err)
    );

    // Reference model: decides acceptance from its own busy window and pushes expected responses.
    always @(posedge clk) begin
      if (rst) begin
        q.delete();
        free_at  = cyc + 1;
        last_pa  = '0;
        last_sel = '0;
        started  = 1;
      end else if (started && valid && cyc >= free_at) begin
        txn_t x;
        int r;
        r     = m_region(vaddr);
        x.t   = cyc;
        x.we  = we;
        x.err = ERR && r == 2;
        x.sel = x.err ? 3'b000 : 3'(1 << r);
        q.push_back(x);
        free_at  = cyc + (x.err ? 2 : W + 3);
        last_pa  = m_paddr(vaddr);
        last_sel = x.sel;
      end
      cyc++;
    end

    // Monitor: compares DUT outputs against the expected window of the head transaction.
    always @(negedge clk) begin
      if (started) begin
        bit has, exp_en, exp_rv;
        txn_t h;
        has = q.size() > 0;
        if (has) h = q[0];
        exp_en = has && !h.err && cyc >= h.t + 1 && cyc <= h.t + 1 + W;
        exp_rv = has && cyc == h.t + (h.err ? 1 : W + 2);
        chk($sformatf("ready[w%0d]", W), 32'(ready), 32'(cyc >= free_at));
        chk($sformatf("tgt_en[w%0d]", W), 32'(tgt_en), 32'(exp_en));
        chk($sformatf("resp_valid[w%0d]", W), 32'(resp_valid), 32'(exp_rv));
        chk($sformatf("paddr[w%0d]", W), 32'(paddr), 32'(last_pa));
        chk($sformatf("tgt_sel[w%0d]", W), 32'(sel), 32'(last_sel));
        if (exp_en) chk($sformatf("tgt_we[w%0d]", W), 32'(tgt_we), 32'(h.we));
        if (exp_rv) begin
          chk($sformatf("resp_err[w%0d]", W), 32'(resp_err), 32'(h.err));
          void'(q.pop_front());
        end else if (!resp_valid) begin
          chk($sformatf("resp_err_idle[w%0d]", W), 32'(resp_err), 32'(0));
        end
      end
    end

    initial begin
      rst = 1'b1; valid = 1'b0; we = 1'b0; vaddr = '0;
      repeat (2) @(posedge clk);
      #2;
      chk($sformatf("reset_tgt_we[w%0d]", W), 32'(tgt_we), 32'(0));
      rst = 1'b0;
      for (int n = 0; n < 800; n++) begin
        @(posedge clk);
        #2;
        rst   = ($urandom_range(0, 39) == 0);
        valid = ($urandom_range(0, 9) < 7);
        we    = 1'($urandom_range(0, 1));
        vaddr = pick();
      end
      valid = 1'b0;
    end
  end

  initial begin
    repeat (900) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
